id_ex_stage: RTL and testbench

Decode-to-execute pipeline register of the 5-stage core. It consumes the register file's combinational read data (RD1/RD2) and the decoded instruction, and registers them for EX. It also bypasses same-cycle writeback data, because the register file writes at posedge and reads combinationally. It detects load-use hazards, inserts one bubble, and counts the bubbles it inserts.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/operand_bypass.sv | 30 +++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the core's pipeline registers.
//   XLEN     : datapath width
//   REG_AW   : register address width
//   CTRL_W   : width of the opaque EX/MEM/WB control bundle
//   ctrl_t   : primary controls plus the opaque bundle, as carried down the pipe
//   REG_ZERO : index of the hard-wired zero register
package pipeline_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [CTRL_W-1:0] ctrl;
  } ctrl_t;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/operand_bypass.sv
// Same-cycle writeback bypass for one source operand. The register file
// writes on the clock edge but is read combinationally, so an instruction in
// ID that reads the register being written this cycle would otherwise see the
// stale value.
//   rs      : source register index from ID
//   rf_data : combinational register file read data for rs
//   wb_we   : writeback enable
//   wb_rd   : writeback register index
//   wb_wd   : writeback data
//   op      : selected operand value
module operand_bypass #(
  parameter int XLEN   = pipeline_pkg::XLEN,
  parameter int REG_AW = pipeline_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  output logic [XLEN-1:0]   op
);

  logic hit;

  // x0 is never bypassed: the register file already returns 0 for it and a
  // write to x0 must stay invisible.
  assign hit = wb_we && (wb_rd != REG_AW'(pipeline_pkg::REG_ZERO)) && (wb_rd == rs);
  assign op  = hit ? wb_wd : rf_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass and load-use bubble insertion.
//   clk, reset_n         : clock, asynchronous active-low reset
//   id_*                 : decoded instruction currently in ID
//   rf_rd1, rf_rd2       : register file read data for id_rs1 / id_rs2
//   wb_we, wb_rd, wb_wd  : writeback port (same signals as the register file write port)
//   ex_hold              : downstream stall, keep EX contents
//   flush                : kill the ID instruction (redirect)
//   load_use_stall       : combinational, IF/ID must hold this cycle
//   ex_*                 : registered copy of the instruction for EX
//   bubble_count         : saturating count of load-use bubbles inserted
module id_ex_stage #(
  parameter int XLEN   = pipeline_pkg::XLEN,
  parameter int REG_AW = pipeline_pkg::REG_AW,
  parameter int CTRL_W = pipeline_pkg::CTRL_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_count
);

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            haz;
  logic            rs1_dep;
  logic            rs2_dep;
  logic            do_clear;
  logic            do_bubble;
  logic            do_capture;

  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_bypass_op1 (
    .rs      (id_rs1),
    .rf_data (rf_rd1),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_wd   (wb_wd),
    .op      (op1)
  );

  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_bypass_op2 (
    .rs      (id_rs2),
    .rf_data (rf_rd2),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_wd   (wb_wd),
    .op      (op2)
  );

  // Hazard looks at the EX register contents, so under ex_hold it keeps
  // reflecting the held load and the stall stretches with the hold.
  assign rs1_dep = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_dep = id_uses_rs2 && (id_rs2 == ex_rd);
  assign haz     = id_valid && ex_valid && ex_mem_read &&
                   (ex_rd != REG_AW'(pipeline_pkg::REG_ZERO)) && (rs1_dep || rs2_dep);

  // A flushed instruction never needs to wait, so it must not freeze IF/ID.
  assign load_use_stall = haz && !flush;

  assign do_bubble  = !flush && !ex_hold && haz;
  assign do_clear   = flush || do_bubble;
  assign do_capture = !flush && !ex_hold && !haz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_ctrl      <= '0;
    end else if (do_clear) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_ctrl      <= '0;
    end else if (do_capture) begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_op1       <= op1;
      ex_op2       <= op2;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      // Controls of an empty slot are forced off so nothing downstream acts on it.
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_mem_write <= id_valid && id_mem_write;
      ex_ctrl      <= id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_count <= '0;
    end else if (do_bubble && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [7:0]  id_ctrl;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        ex_hold, flush;
  logic        load_use_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [7:0]  ex_ctrl;
  logic [3:0]  bubble_count;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CTRL_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_ctrl(id_ctrl), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .ex_hold(ex_hold), .flush(flush), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_ctrl(ex_ctrl), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          stall;
    bit          valid;
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rs1, rs2, rd;
    ctrl_t       c;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   cnt_m;

  ctrl_t C_NONE, C_ADD, C_LW, C_SW, C_I;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit u1, input bit u2, input logic [31:0] imm,
                        input ctrl_t c, input logic [31:0] d1, input logic [31:0] d2);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_imm = imm;
    id_reg_write = c.reg_write; id_mem_read = c.mem_read; id_mem_write = c.mem_write; id_ctrl = c.ctrl;
    rf_rd1 = d1; rf_rd2 = d2;
  endtask

  task automatic push(input string tag, input bit st, input bit v, input logic [31:0] pc,
                      input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input ctrl_t c, input int cnt);
    exp_t x;
    x.tag = tag; x.stall = st; x.valid = v; x.pc = pc; x.op1 = op1; x.op2 = op2; x.imm = imm;
    x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.c = c; x.cnt = 4'(cnt);
    sb.push_back(x);
  endtask

  task automatic push_zero(input string tag, input bit st, input int cnt);
    push(tag, st, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, C_NONE, cnt);
  endtask

  // Monitor: stall is sampled mid-cycle after the driver settles, EX state just after the edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, ".stall"}, 64'(load_use_stall), 64'(e.stall));
        @(posedge clk);
        #1;
        chk({e.tag, ".valid"}, 64'(ex_valid), 64'(e.valid));
        chk({e.tag, ".pc"}, 64'(ex_pc), 64'(e.pc));
        chk({e.tag, ".op1"}, 64'(ex_op1), 64'(e.op1));
        chk({e.tag, ".op2"}, 64'(ex_op2), 64'(e.op2));
        chk({e.tag, ".imm"}, 64'(ex_imm), 64'(e.imm));
        chk({e.tag, ".rs1"}, 64'(ex_rs1), 64'(e.rs1));
        chk({e.tag, ".rs2"}, 64'(ex_rs2), 64'(e.rs2));
        chk({e.tag, ".rd"}, 64'(ex_rd), 64'(e.rd));
        chk({e.tag, ".ctl"}, 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_ctrl}), 64'(e.c));
        chk({e.tag, ".cnt"}, 64'(bubble_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, 64'(load_use_stall), 64'd0);
    chk({tag, ".valid"}, 64'(ex_valid), 64'd0);
    chk({tag, ".pc"}, 64'(ex_pc), 64'd0);
    chk({tag, ".ops"}, {ex_op1, ex_op2}, 64'd0);
    chk({tag, ".imm"}, 64'(ex_imm), 64'd0);
    chk({tag, ".regs"}, 64'({ex_rs1, ex_rs2, ex_rd}), 64'd0);
    chk({tag, ".ctl"}, 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_ctrl}), 64'd0);
    chk({tag, ".cnt"}, 64'(bubble_count), 64'd0);
  endtask

  initial begin
    C_NONE = '0;
    C_ADD  = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, ctrl: 8'h21};
    C_LW   = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, ctrl: 8'h05};
    C_SW   = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1, ctrl: 8'h44};
    C_I    = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, ctrl: 8'h30};

    reset_n = 1'b0;
    set_id(1'b1, 32'h50, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 32'h4, C_LW, 32'h1, 32'h2);
    wb_we = 1'b0; wb_rd = 5'd0; wb_wd = 32'h0; ex_hold = 1'b0; flush = 1'b0;
    #12;
    chk_all_zero("reset");
    #10;
    reset_n = 1'b1;

    // WB bypass on op1
    @(negedge clk);
    set_id(1'b1, 32'h100, 5'd5, 5'd6, 5'd3, 1'b1, 1'b1, 32'h4, C_ADD, 32'h11, 32'h22);
    wb_we = 1'b1; wb_rd = 5'd5; wb_wd = 32'hDEADBEEF;
    push("byp1", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h22, 32'h4, 5'd5, 5'd6, 5'd3, C_ADD, 0);
    // x0 never bypassed
    @(negedge clk);
    set_id(1'b1, 32'h104, 5'd0, 5'd6, 5'd4, 1'b1, 1'b1, 32'h4, C_ADD, 32'h0, 32'h33);
    wb_we = 1'b1; wb_rd = 5'd0; wb_wd = 32'hCAFE0000;
    push("byp_x0", 1'b0, 1'b1, 32'h104, 32'h0, 32'h33, 32'h4, 5'd0, 5'd6, 5'd4, C_ADD, 0);
    // WB bypass on op2
    @(negedge clk);
    set_id(1'b1, 32'h108, 5'd1, 5'd9, 5'd8, 1'b1, 1'b1, 32'h4, C_ADD, 32'hA, 32'hB);
    wb_we = 1'b1; wb_rd = 5'd9; wb_wd = 32'h99;
    push("byp2", 1'b0, 1'b1, 32'h108, 32'hA, 32'h99, 32'h4, 5'd1, 5'd9, 5'd8, C_ADD, 0);
    // load x7 then dependent add on rs2
    @(negedge clk);
    wb_we = 1'b0;
    set_id(1'b1, 32'h10C, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'h4, C_LW, 32'h1000, 32'h0);
    push("lw1", 1'b0, 1'b1, 32'h10C, 32'h1000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, C_LW, 0);
    @(negedge clk);
    set_id(1'b1, 32'h110, 5'd3, 5'd7, 5'd9, 1'b1, 1'b1, 32'h4, C_ADD, 32'h3, 32'h7777);
    push_zero("lu_bubble", 1'b1, 1);
    @(negedge clk);
    push("lu_capture", 1'b0, 1'b1, 32'h110, 32'h3, 32'h7777, 32'h4, 5'd3, 5'd7, 5'd9, C_ADD, 1);
    // load to x0: no stall
    @(negedge clk);
    set_id(1'b1, 32'h114, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 32'h4, C_LW, 32'h2000, 32'h0);
    push("lw_x0", 1'b0, 1'b1, 32'h114, 32'h2000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd0, C_LW, 1);
    @(negedge clk);
    set_id(1'b1, 32'h118, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 32'h4, C_ADD, 32'h0, 32'h0);
    push("nostall_x0", 1'b0, 1'b1, 32'h118, 32'h0, 32'h0, 32'h4, 5'd0, 5'd0, 5'd5, C_ADD, 1);
    // rs2 matches but unused: no stall
    @(negedge clk);
    set_id(1'b1, 32'h11C, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'h4, C_LW, 32'h3000, 32'h0);
    push("lw2", 1'b0, 1'b1, 32'h11C, 32'h3000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, C_LW, 1);
    @(negedge clk);
    set_id(1'b1, 32'h120, 5'd1, 5'd7, 5'd10, 1'b1, 1'b0, 32'h4, C_I, 32'h1, 32'h77);
    push("nostall_unused", 1'b0, 1'b1, 32'h120, 32'h1, 32'h77, 32'h4, 5'd1, 5'd7, 5'd10, C_I, 1);
    // flush together with hazard
    @(negedge clk);
    set_id(1'b1, 32'h124, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'h4, C_LW, 32'h4000, 32'h0);
    push("lw3", 1'b0, 1'b1, 32'h124, 32'h4000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, C_LW, 1);
    @(negedge clk);
    set_id(1'b1, 32'h128, 5'd7, 5'd0, 5'd11, 1'b1, 1'b0, 32'h4, C_ADD, 32'h5, 32'h0);
    flush = 1'b1;
    push_zero("flush_haz", 1'b0, 1);
    // invalid ID slot: data captured, controls forced off
    @(negedge clk);
    flush = 1'b0;
    set_id(1'b0, 32'h12C, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 32'h4, C_ADD, 32'hAA, 32'h0);
    push("invalid", 1'b0, 1'b0, 32'h12C, 32'hAA, 32'h0, 32'h4, 5'd1, 5'd0, 5'd3, C_NONE, 1);
    // hold for three cycles with changing ID
    @(negedge clk);
    set_id(1'b1, 32'h130, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 32'h8, C_SW, 32'h10, 32'h20);
    push("sw", 1'b0, 1'b1, 32'h130, 32'h10, 32'h20, 32'h8, 5'd1, 5'd2, 5'd0, C_SW, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_hold = 1'b1;
      set_id(1'b1, 32'h134 + 32'(4 * i), 5'(i + 3), 5'(i + 4), 5'(i + 20), 1'b1, 1'b1, 32'h4, C_ADD,
             32'h5A5A0000 + 32'(i), 32'hA5A50000 + 32'(i));
      push($sformatf("hold%0d", i), 1'b0, 1'b1, 32'h130, 32'h10, 32'h20, 32'h8, 5'd1, 5'd2, 5'd0, C_SW, 1);
    end
    @(negedge clk);
    ex_hold = 1'b0;
    set_id(1'b1, 32'h140, 5'd4, 5'd5, 5'd12, 1'b1, 1'b1, 32'h4, C_ADD, 32'h44, 32'h55);
    push("hold_rel", 1'b0, 1'b1, 32'h140, 32'h44, 32'h55, 32'h4, 5'd4, 5'd5, 5'd12, C_ADD, 1);
    // hazard stretched by hold
    @(negedge clk);
    set_id(1'b1, 32'h144, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'h4, C_LW, 32'h6000, 32'h0);
    push("lw4", 1'b0, 1'b1, 32'h144, 32'h6000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, C_LW, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_hold = 1'b1;
      set_id(1'b1, 32'h148, 5'd7, 5'd0, 5'd13, 1'b1, 1'b0, 32'h4, C_ADD, 32'h9, 32'h0);
      push($sformatf("haz_hold%0d", i), 1'b1, 1'b1, 32'h144, 32'h6000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, C_LW, 1);
    end
    @(negedge clk);
    ex_hold = 1'b0;
    push_zero("haz_hold_bubble", 1'b1, 2);
    @(negedge clk);
    push("haz_hold_cap", 1'b0, 1'b1, 32'h148, 32'h9, 32'h0, 32'h4, 5'd7, 5'd0, 5'd13, C_ADD, 2);

    // saturation: 20 more load-use pairs
    cnt_m = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_id(1'b1, 32'h200, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'h4, C_LW, 32'h7000, 32'h0);
      push($sformatf("sat_lw%0d", i), 1'b0, 1'b1, 32'h200, 32'h7000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, C_LW, cnt_m);
      @(negedge clk);
      set_id(1'b1, 32'h204, 5'd3, 5'd7, 5'd14, 1'b1, 1'b1, 32'h4, C_ADD, 32'h3, 32'h70);
      cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
      push_zero($sformatf("sat_bub%0d", i), 1'b1, cnt_m);
      @(negedge clk);
      push($sformatf("sat_add%0d", i), 1'b0, 1'b1, 32'h204, 32'h3, 32'h70, 32'h4, 5'd3, 5'd7, 5'd14, C_ADD, cnt_m);
    end

    // async reset while a load-use stall is pending
    @(negedge clk);
    set_id(1'b1, 32'h300, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'h4, C_LW, 32'h8000, 32'h0);
    push("pre_rst_lw", 1'b0, 1'b1, 32'h300, 32'h8000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, C_LW, 15);
    @(posedge clk);
    #3;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    set_id(1'b1, 32'h304, 5'd3, 5'd7, 5'd15, 1'b1, 1'b1, 32'h4, C_ADD, 32'h3, 32'h70);
    #1;
    chk("pre_rst.stall", 64'(load_use_stall), 64'd1);
    chk("pre_rst.valid", 64'(ex_valid), 64'd1);
    chk("pre_rst.cnt", 64'(bubble_count), 64'd15);
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, C_NONE, 32'h0, 32'h0);
    #2;
    reset_n = 1'b1;

    // counter restarts from zero after reset
    @(negedge clk);
    set_id(1'b1, 32'h400, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'h4, C_LW, 32'h9000, 32'h0);
    push("post_lw", 1'b0, 1'b1, 32'h400, 32'h9000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, C_LW, 0);
    @(negedge clk);
    set_id(1'b1, 32'h404, 5'd7, 5'd1, 5'd6, 1'b1, 1'b1, 32'h4, C_ADD, 32'hC, 32'hD);
    push_zero("post_bub", 1'b1, 1);
    @(negedge clk);
    push("post_add", 1'b0, 1'b1, 32'h404, 32'hC, 32'hD, 32'h4, 5'd7, 5'd1, 5'd6, C_ADD, 1);
    @(posedge clk);
    #3;
    chk("final_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
